// File: rtl/audio_nios_lcd_sequencer.sv
// Avalon-MM to HD44780 write sequencer: a 4-entry {rs,byte} FIFO feeds a timed E-strobe FSM.
// Optional macro LCD_BUSY_POLL_EN replaces the fixed post-transfer wait with busy-flag polling.
module audio_nios_lcd_sequencer #(
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 12,
  parameter int HOLD_CYC      = 2,
  parameter int WAIT_CYC      = 2000,
  parameter int WAIT_LONG_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       address,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);
  localparam logic [16:0] SETUP_LD     = 17'(SETUP_CYC - 1);
  localparam logic [16:0] PULSE_LD     = 17'(PULSE_CYC - 1);
  localparam logic [16:0] HOLD_LD      = 17'(HOLD_CYC - 1);
  localparam logic [16:0] WAIT_LD      = 17'(WAIT_CYC - 1);
  localparam logic [16:0] WAIT_LONG_LD = 17'(WAIT_LONG_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, HOLD, WAIT, POLL_SETUP, POLL_PULSE, POLL_HOLD
  } state_t;

  state_t      state, state_next;
  logic [16:0] cnt, cnt_next;

  logic [8:0]  mem [4];
  logic [8:0]  head;
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        full, empty, push, pop, busy;
  logic        out_rs, long_wait, poll_next;
  logic [7:0]  out_byte;
  logic        lcd_e_reg, lcd_rs_reg;
  logic        unused_bits;

  assign empty       = (count == 3'd0);
  assign full        = (count == 3'd4);
  assign busy        = (state != IDLE);
  assign push        = write && !full;
  assign waitrequest = write && full;
  assign readdata    = {busy, full, empty, 2'b00, count};
  assign head        = mem[rd_ptr];
  // Clear (0x01) and home (0x02/0x03) need the long execution time.
  assign long_wait   = !out_rs && (out_byte <= 8'h03);
  assign unused_bits = ^{read, LCD_data};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {address, writedata};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 17'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

`ifdef LCD_BUSY_POLL_EN
  logic poll_busy, lcd_rw_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_busy  <= 1'b0;
      lcd_rw_reg <= 1'b0;
    end else begin
      if (state == POLL_PULSE && cnt == 17'd0) poll_busy <= LCD_data[7];
      lcd_rw_reg <= poll_next;
    end
  end

  assign poll_next = (state_next == POLL_SETUP) || (state_next == POLL_PULSE) ||
                     (state_next == POLL_HOLD);
  assign LCD_RW    = lcd_rw_reg;
`else
  assign poll_next = 1'b0;
  assign LCD_RW    = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    cnt_next   = (cnt == 17'd0) ? 17'd0 : cnt - 17'd1;
    case (state)
      IDLE:  if (!empty) begin
               pop        = 1'b1;
               state_next = SETUP;
             end
      SETUP: if (cnt == 17'd0) state_next = PULSE;
      PULSE: if (cnt == 17'd0) state_next = HOLD;
`ifdef LCD_BUSY_POLL_EN
      HOLD:       if (cnt == 17'd0) state_next = POLL_SETUP;
      POLL_SETUP: if (cnt == 17'd0) state_next = POLL_PULSE;
      POLL_PULSE: if (cnt == 17'd0) state_next = POLL_HOLD;
      POLL_HOLD:  if (cnt == 17'd0) state_next = poll_busy ? POLL_SETUP : IDLE;
`else
      HOLD:  if (cnt == 17'd0) state_next = WAIT;
      WAIT:  if (cnt == 17'd0) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
    // One shared down-counter: reload with N-1 whenever a timed state is entered.
    if (state_next != state) begin
      case (state_next)
        SETUP, POLL_SETUP: cnt_next = SETUP_LD;
        PULSE, POLL_PULSE: cnt_next = PULSE_LD;
        HOLD, POLL_HOLD:   cnt_next = HOLD_LD;
        WAIT:              cnt_next = long_wait ? WAIT_LONG_LD : WAIT_LD;
        default:           cnt_next = 17'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_rs     <= 1'b0;
      out_byte   <= 8'h00;
      lcd_e_reg  <= 1'b0;
      lcd_rs_reg <= 1'b0;
    end else begin
      if (pop) begin
        out_rs   <= head[8];
        out_byte <= head[7:0];
      end
      lcd_e_reg  <= (state_next == PULSE) || (state_next == POLL_PULSE);
      lcd_rs_reg <= poll_next ? 1'b0 : (pop ? head[8] : out_rs);
    end
  end

  assign LCD_E    = lcd_e_reg;
  assign LCD_RS   = lcd_rs_reg;
  assign LCD_data = LCD_RW ? 8'hzz : out_byte;
endmodule

// File: tb/tb_audio_nios_lcd_sequencer.sv
// Scoreboard bench: writes push expected {rs,byte,timing} entries; a pin-level monitor pops and checks.
module tb_audio_nios_lcd_sequencer;
  localparam int SC  = 2;
  localparam int PC  = 12;
  localparam int HC  = 2;
  localparam int WC  = 20;
  localparam int WLC = 60;
`ifdef LCD_BUSY_POLL_EN
  localparam int POLLS_EXP = 4;
`else
  localparam int POLLS_EXP = 0;
`endif

  logic       clk, reset_n, address, write, read;
  logic [7:0] writedata, readdata;
  logic       waitrequest, lcd_e, lcd_rs, lcd_rw;
  wire  [7:0] lcd_data;
  wire        busy = readdata[7];

  typedef struct { logic rs; logic [7:0] data; time t; } exp_t;
  exp_t exp_q [$];

  int   chk_cnt = 0, pass_cnt = 0, e_rises = 0, poll_seen = 0;
  logic mon_en = 1'b0;
  logic [8:0] dir [8] = '{9'h141, 9'h001, 9'h038, 9'h003, 9'h004, 9'h101, 9'h000, 9'h002};

  audio_nios_lcd_sequencer #(
    .SETUP_CYC(SC), .PULSE_CYC(PC), .HOLD_CYC(HC), .WAIT_CYC(WC), .WAIT_LONG_CYC(WLC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write), .read(read),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_data(lcd_data)
  );

`ifdef LCD_BUSY_POLL_EN
  // Display model: reports busy for the first three polls of each transfer.
  assign lcd_data = lcd_rw ? {(poll_seen <= 3), 7'b0} : 8'hzz;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #600000;
    $display("FAIL global_timeout: simulation did not complete, got %0d/%0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int exp_post(input logic rs, input logic [7:0] b);
    return HC + ((!rs && b <= 8'h03) ? WLC : WC);
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_write(input logic a, input logic [7:0] d, output logic stalled);
    int   n;
    exp_t e;
    stalled = 1'b0;
    n = 0;
    address = a; writedata = d; write = 1'b1;
    forever begin
      @(negedge clk);
      if (!waitrequest) break;
      stalled = 1'b1;
      n++;
      if (n > 3000) begin
        chk("write_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    e.rs = a; e.data = d; e.t = $time;
    exp_q.push_back(e);
    $display("write rs=%0d data=%02h stalled=%0d", a, d, stalled);
    #1 write = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin : e_counter
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (lcd_e && !prev) e_rises++;
      prev = lcd_e;
    end
  end

  initial begin : monitor
    int   setup_n, pulse_n, post_n, idle_n, gap_n, polls;
    logic rs_a, rs_b, rs_c, rw_seen, e_last;
    logic [7:0] d_a, d_b, d_c;
    time  idle_t;
    exp_t e;
    idle_n = 0;
    idle_t = 0;
    forever begin
      @(negedge clk);
      if (!reset_n || !mon_en) begin
        idle_n = 0;
        idle_t = 0;
      end else if (!busy) begin
        idle_n++;
      end else begin
        gap_n = idle_n; setup_n = 0; pulse_n = 0; post_n = 0; polls = 0; poll_seen = 0;
        rs_a = lcd_rs; d_a = lcd_data; rw_seen = 1'b0;
        while (reset_n && busy && !lcd_e && setup_n < 100) begin
          rw_seen |= lcd_rw; setup_n++; @(negedge clk);
        end
        rs_b = lcd_rs; d_b = lcd_data;
        while (reset_n && lcd_e && pulse_n < 100) begin
          rw_seen |= lcd_rw; pulse_n++; @(negedge clk);
        end
        rs_c = lcd_rs; d_c = lcd_data; rw_seen |= lcd_rw; e_last = 1'b0;
        while (reset_n && busy && post_n < 1000) begin
          if (lcd_e && !e_last) begin
            polls++; poll_seen = polls; rw_seen |= !lcd_rw;
          end
          e_last = lcd_e; post_n++; @(negedge clk);
        end
        if (reset_n) begin
          $display("xfer rs=%0d data=%02h setup=%0d pulse=%0d post=%0d polls=%0d gap=%0d",
                   rs_b, d_b, setup_n, pulse_n, post_n, polls, gap_n);
          if (exp_q.size() == 0) begin
            chk("unexpected_transfer", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rs", {31'd0, rs_b}, {31'd0, e.rs});
            chk("data", {24'd0, d_b}, {24'd0, e.data});
            chk("setup_len", setup_n, SC);
            chk("pulse_len", pulse_n, PC);
`ifndef LCD_BUSY_POLL_EN
            chk("post_len", post_n, exp_post(e.rs, e.data));
`endif
            chk("poll_pulses", polls, POLLS_EXP);
            chk("lines_stable", {13'd0, rs_a, d_a, rs_c, d_c, rw_seen},
                {13'd0, rs_b, d_b, rs_b, d_b, 1'b0});
            // An entry already queued when the sequencer went idle must start after one idle cycle.
            if (e.t < idle_t) chk("idle_gap", gap_n, 1);
          end
        end
        idle_n = 1;
        idle_t = $time;
      end
    end
  end

  initial begin : stimulus
    logic st;
    int   n, rises_before;
    reset_n = 1'b0; address = 1'b0; write = 1'b0; read = 1'b0; writedata = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1 read = 1'b1;
    #1;
    chk("reset_status", {24'd0, readdata}, 32'h20);
    chk("reset_e", {31'd0, lcd_e}, 32'd0);
    chk("reset_rs", {31'd0, lcd_rs}, 32'd0);
    chk("reset_rw", {31'd0, lcd_rw}, 32'd0);
    chk("reset_data", {24'd0, lcd_data}, 32'd0);
    chk("read_waitrequest", {31'd0, waitrequest}, 32'd0);
    read = 1'b0;

    for (int i = 0; i < 8; i++) do_write(dir[i][8], dir[i][7:0], st);
    drain();

    for (int i = 0; i < 6; i++) begin
      do_write(1'b1, 8'(8'h61 + i), st);
      chk("burst_stall", {31'd0, st}, (i == 5) ? 32'd1 : 32'd0);
    end
    drain();

    for (int i = 0; i < 24; i++) begin
      n = $urandom_range(0, 40);
      repeat (n) @(posedge clk);
      #1;
      if ($urandom_range(0, 2) == 0) do_write(1'b0, 8'($urandom_range(0, 5)), st);
      else do_write(1'($urandom_range(0, 1)), 8'($urandom), st);
    end
    drain();
    read = 1'b1;
    #1;
    chk("idle_status", {24'd0, readdata}, 32'h20);
    chk("idle_read_waitrequest", {31'd0, waitrequest}, 32'd0);
    read = 1'b0;

    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) do_write(1'b1, 8'(8'h50 + i), st);
    n = 0;
    while (!lcd_e && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("pulse_seen", {31'd0, lcd_e}, 32'd1);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midpulse_reset_e", {31'd0, lcd_e}, 32'd0);
    chk("midpulse_reset_rs", {31'd0, lcd_rs}, 32'd0);
    chk("midpulse_reset_rw", {31'd0, lcd_rw}, 32'd0);
    chk("midpulse_reset_status", {24'd0, readdata}, 32'h20);
    chk("midpulse_reset_data", {24'd0, lcd_data}, 32'd0);
    exp_q.delete();
    rises_before = e_rises;
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("no_pulse_after_reset", e_rises, rises_before);
    chk("post_reset_status", {24'd0, readdata}, 32'h20);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
